// File: rtl/compk_accum_ctrl_if.sv
// Bundle between the K-compare accumulator controller and its environment.
// The slave side is the controller; the master side drives start/K/step/comp_out.
interface compk_accum_ctrl_if #(
    parameter int DW = 6
) ();
    logic          start;
    logic [DW-1:0] K_in;
    logic [DW-1:0] step;
    logic          comp_out;
    logic [DW-1:0] K_reg;
    logic [DW-1:0] temp_adder;
    logic [DW-1:0] count;
    logic          busy;
    logic          done;
    logic          ovf;
    logic          err;

    modport master (
        output start, K_in, step, comp_out,
        input  K_reg, temp_adder, count, busy, done, ovf, err
    );

    modport slave (
        input  start, K_in, step, comp_out,
        output K_reg, temp_adder, count, busy, done, ovf, err
    );
endinterface

// File: rtl/compk_accum_ctrl.sv
// Accumulates step into a running sum until the external compK reports
// K < sum, then reports how many additions it took.
module compk_accum_ctrl #(
    parameter int DW = 6
) (
    input logic               clk,
    input logic               rst,
    compk_accum_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [DW-1:0] r_k;
    logic [DW-1:0] r_step;
    logic [DW-1:0] r_sum;
    logic [DW-1:0] r_cnt;
    logic          r_ovf;
    logic          r_err;
    logic [DW-1:0] w_k;
    logic [DW-1:0] w_step;
    logic [DW-1:0] w_sum;
    logic [DW-1:0] w_cnt;
    logic          w_ovf;
    logic          w_err;
    logic [DW:0]   w_add;

    assign w_add = {1'b0, r_sum} + {1'b0, r_step};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_step  <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_k     <= w_k;
            r_step  <= w_step;
            r_sum   <= w_sum;
            r_cnt   <= w_cnt;
            r_ovf   <= w_ovf;
            r_err   <= w_err;
        end
    end

    always_comb begin
        w_next = r_state;
        w_k    = r_k;
        w_step = r_step;
        w_sum  = r_sum;
        w_cnt  = r_cnt;
        w_ovf  = r_ovf;
        w_err  = r_err;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_k    = bus.K_in;
                    w_step = bus.step;
                    w_sum  = '0;
                    w_cnt  = '0;
                    w_ovf  = 1'b0;
                    w_err  = (bus.step == '0);
                    w_next = (bus.step == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                // A carry ends the run with the last in-range sum kept.
                if (bus.comp_out) begin
                    w_next = S_DONE;
                end else if (w_add[DW]) begin
                    w_ovf  = 1'b1;
                    w_next = S_DONE;
                end else begin
                    w_sum = w_add[DW-1:0];
                    w_cnt = r_cnt + DW'(1);
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign bus.K_reg      = r_k;
    assign bus.temp_adder = r_sum;
    assign bus.count      = r_cnt;
    assign bus.busy       = (r_state == S_ACCUM);
    assign bus.done       = (r_state == S_DONE);
    assign bus.ovf        = r_ovf;
    assign bus.err        = r_err;
endmodule
